clk_sel_ctrl: RTL and testbench

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// ---------------------------------------------------------------------------
// clk_sel_ctrl
// Glitch-free source switch controller for a pixel pipeline. A change of
// source is deferred to a frame boundary (or forced after a timeout), and the
// downstream pipeline is gated off for a fixed gap before and after the mux
// select flips, so the select never moves while the pipeline runs.
//
// Parameters
//   GAP_CYCLES    gated-off cycles before and after the select change (1..255)
//   TIMEOUT       max cycles to wait for frame_end before forcing (2..65535)
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   req_valid     source-change request strobe
//   sel_req       requested source (0 = A, 1 = B), qualified by req_valid
//   frame_end     single-cycle pulse on the last pixel of a frame
//   sel           registered source mux select
//   gate_en       registered pipeline enable (1 = run)
//   busy          registered, high while a switch sequence is in progress
//   ack           registered single-cycle completion pulse
//   timeout_flag  registered sticky flag: last switch was forced by timeout
// ---------------------------------------------------------------------------
module clk_sel_ctrl #(
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic sel_req,
   input  logic frame_end,
   output logic sel,
   output logic gate_en,
   output logic busy,
   output logic ack,
   output logic timeout_flag
);

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      WAIT_FRAME = 3'd1,
      GATE_OFF   = 3'd2,
      SWITCH     = 3'd3,
      SETTLE     = 3'd4
   } state_t;

   // Terminal counts; counters are sized for the largest legal parameters
   // and are cleared on every phase entry, so they never wrap.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

   state_t      state_r, state_s;
   logic [15:0] wait_cnt_r, wait_cnt_s;
   logic [7:0]  gap_cnt_r, gap_cnt_s;
   logic        target_r, target_s;
   logic        sel_r, sel_s;
   logic        gate_en_r, gate_en_s;
   logic        busy_r, busy_s;
   logic        ack_r, ack_s;
   logic        tflag_r, tflag_s;

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= RUN;
         wait_cnt_r <= 16'd0;
         gap_cnt_r  <= 8'd0;
         target_r   <= 1'b0;
         sel_r      <= 1'b0;
         gate_en_r  <= 1'b1;
         busy_r     <= 1'b0;
         ack_r      <= 1'b0;
         tflag_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         gap_cnt_r  <= gap_cnt_s;
         target_r   <= target_s;
         sel_r      <= sel_s;
         gate_en_r  <= gate_en_s;
         busy_r     <= busy_s;
         ack_r      <= ack_s;
         tflag_r    <= tflag_s;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that each registered output lines up with the state it belongs to.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      gap_cnt_s  = gap_cnt_r;
      target_s   = target_r;
      sel_s      = sel_r;
      gate_en_s  = gate_en_r;
      busy_s     = busy_r;
      ack_s      = 1'b0;
      tflag_s    = tflag_r;

      case (state_r)
         RUN: begin
            if (req_valid) begin
               if (sel_req == sel_r) begin
                  // Already on the requested source: confirm only.
                  ack_s = 1'b1;
               end else begin
                  target_s   = sel_req;
                  wait_cnt_s = 16'd0;
                  tflag_s    = 1'b0;
                  busy_s     = 1'b1;
                  state_s    = WAIT_FRAME;
               end
            end else begin
               state_s = RUN;
            end
         end

         WAIT_FRAME: begin
            // frame_end takes priority over an expiring wait counter.
            if (frame_end) begin
               wait_cnt_s = 16'd0;
               gap_cnt_s  = 8'd0;
               gate_en_s  = 1'b0;
               state_s    = GATE_OFF;
            end else if (wait_cnt_r == WAIT_LAST) begin
               wait_cnt_s = 16'd0;
               gap_cnt_s  = 8'd0;
               gate_en_s  = 1'b0;
               tflag_s    = 1'b1;
               state_s    = GATE_OFF;
            end else begin
               wait_cnt_s = wait_cnt_r + 16'd1;
            end
         end

         GATE_OFF: begin
            if (gap_cnt_r == GAP_LAST) begin
               gap_cnt_s = 8'd0;
               state_s   = SWITCH;
            end else begin
               gap_cnt_s = gap_cnt_r + 8'd1;
            end
         end

         SWITCH: begin
            // The select flips at the end of this single, fully gated cycle.
            sel_s     = target_r;
            gap_cnt_s = 8'd0;
            state_s   = SETTLE;
         end

         SETTLE: begin
            if (gap_cnt_r == GAP_LAST) begin
               gap_cnt_s = 8'd0;
               gate_en_s = 1'b1;
               busy_s    = 1'b0;
               ack_s     = 1'b1;
               state_s   = RUN;
            end else begin
               gap_cnt_s = gap_cnt_r + 8'd1;
            end
         end

         default: begin
            state_s    = RUN;
            wait_cnt_s = 16'd0;
            gap_cnt_s  = 8'd0;
            gate_en_s  = 1'b1;
            busy_s     = 1'b0;
         end
      endcase
   end

   assign sel          = sel_r;
   assign gate_en      = gate_en_r;
   assign busy         = busy_r;
   assign ack          = ack_r;
   assign timeout_flag = tflag_r;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_sel_ctrl
// Directed bench for clk_sel_ctrl with GAP_CYCLES=4, TIMEOUT=8. A vector
// table covers reset, same-source ack, a frame-aligned switch with an ignored
// request while busy, and frame_end ignored in RUN; hand-written sequences
// cover timeout, the frame_end/timeout tie, sticky flag behaviour and reset
// in the middle of a switch. Outputs are packed {sel,gate_en,busy,ack,tflag}.
// ---------------------------------------------------------------------------
module tb_clk_sel_ctrl;

   logic clk;
   logic rst;
   logic req_valid;
   logic sel_req;
   logic frame_end;
   logic sel;
   logic gate_en;
   logic busy;
   logic ack;
   logic timeout_flag;

   int tests_run;
   int tests_failed;

   clk_sel_ctrl #(
      .GAP_CYCLES(4),
      .TIMEOUT   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .sel_req     (sel_req),
      .frame_end   (frame_end),
      .sel         (sel),
      .gate_en     (gate_en),
      .busy        (busy),
      .ack         (ack),
      .timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic       rv;
      logic       sr;
      logic       fe;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[20];

   // Apply inputs on the falling edge, let one rising edge pass, sample #1 later.
   task automatic drive(input logic r, input logic rv, input logic sr, input logic fe);
      @(negedge clk);
      rst       = r;
      req_valid = rv;
      sel_req   = sr;
      frame_end = fe;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input logic [4:0] exp);
      logic [4:0] act;
      act = {sel, gate_en, busy, ack, timeout_flag};
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: {sel,gate_en,busy,ack,tflag} got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   int n;
   int low;
   int acks;
   int bad;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      sel_req      = 1'b0;
      frame_end    = 1'b0;

      // ---------------- table: frame-aligned switch ----------------
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b01000}; // reset
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01000}; // idle
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01010}; // same source -> ack
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01000}; // ack lasts one cycle
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b01100}; // accept -> busy
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b01100}; // request while busy ignored
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b01100};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00100}; // frame_end -> gate off
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00100}; // SWITCH, sel still old
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10100}; // sel flipped, still gated
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10100};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10100};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b10100}; // 9th low cycle
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11010}; // RUN: gate, ack, !busy
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11000};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11010}; // same source (B) -> ack
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b11000}; // frame_end ignored in RUN

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].r, tbl[i].rv, tbl[i].sr, tbl[i].fe);
         check_out($sformatf("vec%0d", i), tbl[i].exp);
      end

      // ---------------- timeout-forced switch ----------------
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check_out("to_reset", 5'b01000);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_out("to_accept", 5'b01100);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         n++;
         if (gate_en == 1'b0) break;
      end
      check_int("to_wait_cycles", n, 8);
      check_out("to_gate_off", 5'b00101);
      low  = 1;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         if (ack) acks++;
         if (gate_en) break;
         low++;
      end
      check_int("to_low_cycles", low, 9);
      check_int("to_acks", acks, 1);
      check_out("to_done", 5'b11011);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_out("to_flag_held", 5'b11001);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_out("to_same_src_keeps_flag", 5'b11011);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      check_out("to_accept_clears_flag", 5'b11100);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check_out("to_reset_mid_wait", 5'b01000);

      // ---------------- tie: frame_end as counter hits TIMEOUT-1 ----------
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_out("tie_accept_after_rst", 5'b01100);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_out("tie_still_waiting", 5'b01100);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_out("tie_gate_off_no_flag", 5'b00100);
      acks = 0;
      bad  = 1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         if (ack) acks++;
         if (gate_en) begin
            bad = 0;
            break;
         end
      end
      check_int("tie_completed", bad, 0);
      check_int("tie_acks", acks, 1);
      check_out("tie_done", 5'b11010);

      // ---------------- reset in the middle of GATE_OFF ----------------
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check_out("rm_reset", 5'b01000);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check_out("rm_accept", 5'b01100);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_out("rm_gate_off", 5'b00100);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check_out("rm_in_gap", 5'b00100);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check_out("rm_after_reset", 5'b01000);
      acks = 0;
      bad  = 0;
      for (int i = 0; i < 30; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0);
         if (ack) acks++;
         if (!gate_en || busy || sel) bad++;
      end
      check_int("rm_no_ack", acks, 0);
      check_int("rm_stays_idle", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
